// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU program-counter stage.
// Jump-bit encodings follow the Hack C-instruction j1 j2 j3 field.
package hack_pkg;

    // Default ROM address width of the Hack platform (32K words).
    localparam int unsigned ROM_ADDR_W = 15;

    // Jump-field encodings, {j1, j2, j3}.
    localparam logic [2:0] JMP_NULL = 3'b000;
    localparam logic [2:0] JGT      = 3'b001;
    localparam logic [2:0] JEQ      = 3'b010;
    localparam logic [2:0] JGE      = 3'b011;
    localparam logic [2:0] JLT      = 3'b100;
    localparam logic [2:0] JNE      = 3'b101;
    localparam logic [2:0] JLE      = 3'b110;
    localparam logic [2:0] JMP      = 3'b111;

    // Source of the next program-counter value, in decreasing priority.
    typedef enum logic [1:0] {
        PcRestart,
        PcHold,
        PcJump,
        PcIncr
    } pc_sel_e;

endpackage

// File: rtl/jump_cond.sv
// Jump-condition decode: purely combinational evaluation of the C-instruction
// jump field against the ALU status flags. zr & ng together is not special-cased.
module jump_cond (
    input  logic [2:0] jump_bits,
    input  logic       zr,
    input  logic       ng,
    input  logic       is_c_instr,
    output logic       jump_taken
);

    logic j1, j2, j3;
    logic pos;

    assign j1  = jump_bits[2];
    assign j2  = jump_bits[1];
    assign j3  = jump_bits[0];
    assign pos = ~ng & ~zr;

    // Jump when any selected relation (lt / eq / gt) of the ALU result holds.
    always_comb begin
        jump_taken = is_c_instr & ((j1 & ng) | (j2 & zr) | (j3 & pos));
    end

endmodule

// File: rtl/hack_pc.sv
// Hack CPU program counter with jump decision.
// Priority per edge: restart > (halted freeze) > stall > jump > increment.
// Optional macro HACK_PC_HALT_DETECT_EN adds a sticky 'halted' output that is
// set by the "(END) @END 0;JMP" self-jump idiom and freezes the pc.
module hack_pc
    import hack_pkg::*;
#(
    parameter int unsigned       WIDTH        = ROM_ADDR_W,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic             is_c_instr,
    input  logic [2:0]       jump_bits,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] pc,
`ifdef HACK_PC_HALT_DETECT_EN
    output logic             halted,
`endif
    output logic             jump_taken
);

    logic [WIDTH-1:0] pc_q, pc_d;
    pc_sel_e          pc_sel;
    logic             frozen;

    jump_cond u_jump_cond (
        .jump_bits  (jump_bits),
        .zr         (zr),
        .ng         (ng),
        .is_c_instr (is_c_instr),
        .jump_taken (jump_taken)
    );

`ifdef HACK_PC_HALT_DETECT_EN
    logic halted_q, halted_d;

    // Sticky halt: set on an enabled self-jump, cleared only by restart (or rst).
    always_comb begin
        halted_d = halted_q;
        if (restart) begin
            halted_d = 1'b0;
        end else if (en && jump_taken && (a_reg == pc_q)) begin
            halted_d = 1'b1;
        end
    end

    // Halt flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign frozen = halted_q;
    assign halted = halted_q;
`else
    assign frozen = 1'b0;
`endif

    // Select the next-pc source by priority, then form the next value.
    always_comb begin
        pc_sel = PcIncr;
        if (restart) begin
            pc_sel = PcRestart;
        end else if (frozen || !en) begin
            pc_sel = PcHold;
        end else if (jump_taken) begin
            pc_sel = PcJump;
        end

        pc_d = pc_q;
        unique case (pc_sel)
            PcRestart: pc_d = RESET_VECTOR;
            PcHold:    pc_d = pc_q;
            PcJump:    pc_d = a_reg;
            PcIncr:    pc_d = pc_q + 1'b1;  // wraps modulo 2^WIDTH
            default:   pc_d = pc_q;
        endcase
    end

    // Program-counter register; rst loads the reset vector immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_hack_pc.sv
// Self-checking bench for hack_pc: directed scenarios plus randomized stimulus
// against a behavioural model; jump_cond is also checked exhaustively.
`timescale 1ns/1ps
module tb_hack_pc;
    import hack_pkg::*;

    localparam int unsigned W = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         restart;
    logic         en;
    logic         is_c_instr;
    logic [2:0]   jump_bits;
    logic         zr;
    logic         ng;
    logic [W-1:0] a_reg;
    logic [W-1:0] pc;
    logic         jump_taken;
`ifdef HACK_PC_HALT_DETECT_EN
    logic         halted;
`endif

    // Standalone jump_cond instance for the exhaustive sweep.
    logic [2:0] sa_bits;
    logic       sa_zr, sa_ng, sa_c, sa_jt;

    int vectors = 0;
    int miscompares = 0;

    // Reference state.
    logic [W-1:0] m_pc;
    logic         m_halt;

    always #5 clk = ~clk;

    hack_pc #(
        .WIDTH        (W),
        .RESET_VECTOR ('0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .en         (en),
        .is_c_instr (is_c_instr),
        .jump_bits  (jump_bits),
        .zr         (zr),
        .ng         (ng),
        .a_reg      (a_reg),
        .pc         (pc),
`ifdef HACK_PC_HALT_DETECT_EN
        .halted     (halted),
`endif
        .jump_taken (jump_taken)
    );

    jump_cond u_sa (
        .jump_bits  (sa_bits),
        .zr         (sa_zr),
        .ng         (sa_ng),
        .is_c_instr (sa_c),
        .jump_taken (sa_jt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level condition: jump if the ALU result relation (<0, ==0, >0) is selected.
    function automatic logic model_jump(input logic c, input logic [2:0] jb,
                                        input logic z, input logic n);
        logic lt, eq, gt;
        lt = n;
        eq = z;
        gt = !n && !z;
        return c && ((jb[2] && lt) || (jb[1] && eq) || (jb[0] && gt));
    endfunction

    // Apply one cycle of inputs (called just after a falling edge).
    task automatic step(input logic r, input logic e, input logic c, input logic [2:0] jb,
                        input logic z, input logic n, input logic [W-1:0] a);
        logic jt;
        restart = r; en = e; is_c_instr = c; jump_bits = jb; zr = z; ng = n; a_reg = a;
        #1;
        jt = model_jump(c, jb, z, n);
        check("jump_taken", {31'd0, jump_taken}, {31'd0, jt});
        @(posedge clk);
        if (r) begin
            m_pc = '0;
            m_halt = 1'b0;
        end else if (m_halt || !e) begin
            m_pc = m_pc;
        end else if (jt) begin
`ifdef HACK_PC_HALT_DETECT_EN
            if (a == m_pc) m_halt = 1'b1;
`endif
            m_pc = a;
        end else begin
            m_pc = m_pc + 1'b1;
        end
        @(negedge clk);
        check("pc", {17'd0, pc}, {17'd0, m_pc});
`ifdef HACK_PC_HALT_DETECT_EN
        check("halted", {31'd0, halted}, {31'd0, m_halt});
`endif
    endtask

    initial begin
        rst = 1'b1; restart = 1'b0; en = 1'b1; is_c_instr = 1'b0;
        jump_bits = JMP_NULL; zr = 1'b0; ng = 1'b0; a_reg = '0;
        sa_bits = '0; sa_zr = 1'b0; sa_ng = 1'b0; sa_c = 1'b0;
        m_pc = '0; m_halt = 1'b0;

        // Exhaustive jump_cond sweep.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            {sa_c, sa_bits, sa_zr} = v;
            sa_ng = v[0] ^ v[4];
            sa_zr = v[0];
            sa_ng = v[1] ^ 1'b0;
            {sa_c, sa_bits} = v[4:1];
            sa_zr = v[0];
            sa_ng = i[1] ^ i[4];
            #1;
            check("jc_sweep", {31'd0, sa_jt}, {31'd0, model_jump(sa_c, sa_bits, sa_zr, sa_ng)});
        end
        // Cover all zr/ng combos for every bits/c pair explicitly.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            {sa_c, sa_bits, sa_zr} = v;
            for (int n = 0; n < 2; n++) begin
                sa_ng = n[0];
                #1;
                check("jc_all", {31'd0, sa_jt}, {31'd0, model_jump(sa_c, sa_bits, sa_zr, sa_ng)});
            end
        end

        // 1. Reset held for two cycles, then count.
        @(negedge clk);
        #1 check("rst_pc", {17'd0, pc}, 32'd0);
        @(negedge clk);
        check("rst_hold", {17'd0, pc}, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, JMP_NULL, 1'b0, 1'b0, '0);
        check("count1", {17'd0, pc}, 32'd1);
        step(1'b0, 1'b1, 1'b0, JMP_NULL, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, JMP_NULL, 1'b0, 1'b0, '0);
        check("count3", {17'd0, pc}, 32'd3);

        // 2. Conditional jump taken / not taken.
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd5);
        step(1'b0, 1'b1, 1'b1, JEQ, 1'b1, 1'b0, 15'd100);
        check("jeq_taken", {17'd0, pc}, 32'd100);
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd5);
        step(1'b0, 1'b1, 1'b1, JEQ, 1'b0, 1'b0, 15'd100);
        check("jeq_not", {17'd0, pc}, 32'd6);

        // 3. A-instruction never jumps; stall holds.
        step(1'b0, 1'b1, 1'b0, JMP, 1'b0, 1'b0, 15'd42);
        check("a_instr", {17'd0, pc}, 32'd7);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, JMP, 1'b0, 1'b1, 15'd42);
        check("stall", {17'd0, pc}, 32'd7);

        // 4. Restart beats stall and jump.
        step(1'b1, 1'b0, 1'b1, JMP, 1'b0, 1'b0, 15'd99);
        check("restart_prio", {17'd0, pc}, 32'd0);

        // 5. Wrap-around, then async reset between edges.
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'h7fff);
        step(1'b0, 1'b1, 1'b0, JMP_NULL, 1'b0, 1'b0, '0);
        check("wrap", {17'd0, pc}, 32'd0);
        step(1'b0, 1'b1, 1'b1, JGT, 1'b0, 1'b0, 15'd1234);
        #2 rst = 1'b1;
        #1 check("async_rst", {17'd0, pc}, 32'd0);
        m_pc = '0; m_halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifdef HACK_PC_HALT_DETECT_EN
        // 6. Halt detection.
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd20);
        check("halt_pre", {31'd0, halted}, 32'd0);
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd20);
        check("halt_set", {31'd0, halted}, 32'd1);
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd50);
        check("halt_freeze", {17'd0, pc}, 32'd20);
        step(1'b1, 1'b1, 1'b0, JMP_NULL, 1'b0, 1'b0, '0);
        check("halt_clear", {31'd0, halted}, 32'd0);
`else
        // Self-jump reloads the same value each cycle.
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd20);
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd20);
        step(1'b0, 1'b1, 1'b1, JMP, 1'b0, 1'b0, 15'd50);
        check("self_jump", {17'd0, pc}, 32'd50);
`endif

        // Randomized phase.
        for (int k = 0; k < 400; k++) begin
            logic [W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? m_pc : W'($urandom);
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
